// File: rtl/mem_ctrl.sv
// mem_ctrl: multi-cycle load/store controller between the datapath and the
// unified memory port. Accepts one request at a time. The request is aligned
// to a 32-bit word access and driven onto the memory handshake. Load data is
// extracted and extended into the MDR holding register.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. On the memory side, the strobes stay high
// for the whole ACCESS state. The access completes on the first edge where
// mem_resp is high. done is a one-cycle pulse, and err qualifies it.
module mem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mdr,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] mdr_q, mdr_d;
  logic        err_q, err_d;

  logic        illegal;
  logic [31:0] shifted;
  logic [31:0] extracted;

  // Strobes and status are decoded from state only. This lets reset drop them at once.
  assign req_ready       = (state_q == IDLE);
  assign mem_read        = (state_q == ACCESS) & ~we_q;
  assign mem_write       = (state_q == ACCESS) & we_q;
  assign done            = (state_q == DONE);
  assign err             = err_q;
  assign mem_address     = addr_q;
  assign mem_byte_enable = be_q;
  assign mem_wdata       = wdata_q;
  assign mdr             = mdr_q;
  assign dbg_state       = state_q;

  // Classify the incoming request and extract/extend the returning load data.
  always_comb begin
    illegal = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   extracted = {{24{shifted[7] & ~uns_q}}, shifted[7:0]};
      2'b01:   extracted = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
      default: extracted = shifted;
    endcase
  end

  // Next-state logic: request capture, wait counting, timeout and MDR update.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    mdr_d   = mdr_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          size_d = req_size;
          uns_d  = req_unsigned;
          lane_d = req_addr[1:0];
          addr_d = {req_addr[31:2], 2'b00};
          cnt_d  = 16'd0;
          case (req_size)
            2'b00: begin
              be_d    = 4'b0001 << req_addr[1:0];
              wdata_d = {4{req_wdata[7:0]}};
            end
            2'b01: begin
              be_d    = 4'b0011 << req_addr[1:0];
              wdata_d = {2{req_wdata[15:0]}};
            end
            default: begin
              be_d    = 4'hF;
              wdata_d = req_wdata;
            end
          endcase
          // Loads always read the full word; extraction picks the lanes later.
          if (!req_we) be_d = 4'hF;
          if (illegal) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // A response in the timeout cycle still wins and completes cleanly.
        if (mem_resp) begin
          state_d = DONE;
          if (!we_q) mdr_d = extracted;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 16'd0;
      mdr_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Multi-cycle load/store controller between the datapath and the unified memory port. It accepts one load or store request, aligns it to a 32-bit word access and drives the memory handshake. It then extracts and sign- or zero-extends load data into a holding register (MDR). That register feeds the MDR input of the datapath's register-writeback and ALU-operand select muxes.

## Interface
- TIMEOUT, 255: maximum cycles spent in ACCESS waiting for mem_resp before aborting; legal 1..65535.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  datapath has a request.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_byte_enable  out  4  active lanes for stores; 4'hF for loads.
- mem_wdata  out  32  lane-replicated store data.
- mem_resp  in  1  memory completes the access this cycle.
- mem_rdata  in  32  read data, valid with mem_resp.
- mdr  out  32  extended load result.
- done  out  1  one-cycle completion pulse, loads and stores.
- err  out  1  qualifies done: misaligned, illegal size or timeout.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, size, unsigned, addr and wdata.
  - Misaligned or illegal requests go to DONE with err=1; they never raise mem_read or mem_write.
  - All other requests go to ACCESS.
- Alignment rules: byte, any address; half, addr[0]=0; word, addr[1:0]=00; size 11, always illegal.
- ACCESS:
  - mem_read=~we and mem_write=we.
  - mem_address, mem_byte_enable and mem_wdata are held constant for the whole state.
  - On mem_resp, go to DONE. For loads, capture the extracted data into mdr.
  - If the wait counter reaches TIMEOUT without mem_resp, drop the strobes, go to DONE with err=1 and leave mdr unchanged.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<addr[1:0].
  - word: 4'hF.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extract:
  - Compute s = mem_rdata >> (8*addr[1:0]).
  - byte: extend s[7:0] to 32 bits.
  - half: extend s[15:0] to 32 bits.
  - word: s unchanged.
  - Extension is sign or zero per req_unsigned.
- DONE:
  - done=1 for exactly one cycle, with err valid in the same cycle.
  - Next state is IDLE unconditionally.
  - A req_valid arriving during DONE is not accepted until IDLE.
- mdr holds its value until the next successful load completes. Stores, errors and timeouts do not alter it.
- A mem_resp outside ACCESS is ignored.

## Timing
- Reset (asynchronous, immediate on rst_n low):
  - State goes to IDLE.
  - mem_read, mem_write, done, err, mdr and the wait counter all go to 0.
  - mem_address, mem_byte_enable and mem_wdata go to 0.
  - req_ready=1 once in IDLE.
- Reset mid-ACCESS drops the strobes in the same cycle without waiting for a clock edge. Any later mem_resp is ignored.
- Cycle timeline:
  - Request accepted at edge N, leaving IDLE.
  - Strobes high during cycle N+1.
  - mem_resp in cycle N+1 gives done in cycle N+2.
  - Minimum latency from accept to done is 2 cycles; in general it is 2+k for k wait cycles.
- Error path latency: done and err are asserted in cycle N+1.
- Timeout: the counter starts at 0 on ACCESS entry and increments each cycle without mem_resp. When the count equals TIMEOUT-1, the following cycle is DONE with err=1.
- If mem_resp and the timeout coincide in the same cycle, mem_resp wins: the access completes normally with err=0.
- All outputs are registered or decoded from state only. There is no combinational path from req_* or mem_* inputs to any output.
- Throughput: one access every 3 cycles minimum, back-to-back.

## Test plan
- Reset, then a word load at 0x1000 with mem_resp one cycle later and mem_rdata=0xDEADBEEF:
  - Strobes: mem_read=1 for one cycle, mem_address=0x1000, byte enables 4'hF.
  - Completion: done in cycle N+2, mdr=0xDEADBEEF, err=0.
- Byte load at 0x1003 with mem_rdata=0x80FF_0000:
  - Signed (req_unsigned=0): mdr=0xFFFFFF80.
  - Unsigned (req_unsigned=1): mdr=0x00000080.
- Half store at 0x2002 with wdata=0x0000_1234:
  - mem_write=1, mem_address=0x2000, byte enables 4'b1100, mem_wdata=0x12341234.
  - done=1 and mdr unchanged.
- Misaligned word load at 0x1001, then a size=11 request:
  - Each yields done=err=1 in cycle N+1.
  - mem_read and mem_write stay 0 throughout.
- TIMEOUT=4 with no mem_resp:
  - Strobes stay high for exactly 4 cycles, then done=err=1 and mdr keeps its prior value.
  - Rerun with mem_resp on the 4th cycle: err=0.
- rst_n pulled low during the 2nd wait cycle of a store:
  - mem_write falls without a clock edge and req_ready=1 after release.
  - A late mem_resp produces no done.
